pulse_dispatch_arbiter: RTL and testbench
=========================================

Name: pulse_dispatch_arbiter

Overview:
Shares the single pulse_engine between NUM_CH independent pulse sources, for example per-qubit descriptor streams or multiple cores.
- Each channel owns a one-deep holding slot.
- A slot becomes eligible once the global counter reaches its t_start.
- A round-robin arbiter issues eligible pulses to the engine over a valid/ready handshake.
- After each issue, the block blocks further issues for t_len plus GUARD_CYCLES cycles.
- Sits between the per-channel pulse_fetch outputs and pulse_engine; time_now comes from the shared counter.

Parameters:
NUM_CH, 4, number of requesting channels (2..8)
GUARD_CYCLES, 2, idle cycles inserted after every pulse (0 allowed)
FREQ_W/PHASE_W/AMP_W/TSTART_W/TLEN_W/ENV_W, 32/16/16/32/16/10, field widths; TSTART_W equals the counter width

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low
time_now  in  TSTART_W  global counter value
s_valid  in  NUM_CH  per-channel descriptor valid
s_ready  out  NUM_CH  per-channel slot empty
s_freq/s_phase/s_amp/s_tstart/s_tlen/s_env  in  [NUM_CH][field_W]  per-channel pulse fields
m_valid  out  1  pulse offered to the engine
m_ready  in  1  engine accepts
m_freq/m_phase/m_amp/m_tstart/m_tlen/m_env  out  field_W  granted pulse fields
m_ch  out  $clog2(NUM_CH)  granted channel index
busy  out  1  high when state is ISSUE, PLAY or GAP
late_flag  out  NUM_CH  sticky: pulse was granted after its t_start
late_clr  in  NUM_CH  clears the matching late_flag bits

Behaviour:
Reset:
- Slots empty; s_ready all 1.
- m_valid=0 and all m_* fields 0.
- busy=0, late_flag=0, RR pointer=0, state=IDLE.
- Reset mid-pulse drops all held slots and any in-flight offer.

Slot load:
- s_ready[i] = ~full[i], driven purely from a register.
- Load occurs on s_valid[i] & s_ready[i].
- A slot freed on edge k shows ready from cycle k+1. There is no same-cycle bypass.

Eligibility:
- elig[i] = full[i] & (signed(time_now - tstart[i]) >= 0).
- The difference is taken modulo 2^TSTART_W, so eligibility is correct across counter wrap.
- A t_start more than 2^(TSTART_W-1) in the past reads as future; software must avoid this.

State IDLE:
- If any elig, select the first eligible channel at or after the RR pointer, wrapping.
- At the clock edge, latch its fields and m_ch; set m_valid=1; go to ISSUE.
- If time_now != tstart of the winner at that edge, set late_flag[winner].
- Latency: a slot eligible in cycle c gives m_valid=1 in cycle c+1.

State ISSUE:
- m_* held stable while m_valid=1 and m_ready=0.
- On the m_valid & m_ready edge:
  - m_valid goes to 0 and full[winner] goes to 0.
  - RR pointer becomes winner+1 mod NUM_CH.
  - Countdown loads t_len.
  - Next state: PLAY if t_len>0, else GAP if GUARD_CYCLES>0, else IDLE.

State PLAY:
- Countdown decrements each cycle. At countdown==1, go to GAP, or to IDLE if GUARD_CYCLES=0.
- Dwell is exactly t_len cycles.

State GAP:
- Lasts exactly GUARD_CYCLES cycles, then IDLE.

Concurrency and flags:
- Slots may keep loading in every state.
- A slot loaded while busy becomes eligible but waits for IDLE.
- late_flag: set has priority over late_clr in the same cycle for the same bit.
- Multiple eligible channels in IDLE: only one grant per IDLE visit; the others wait in their slots.

Decomposition:
Shared package pulse_pkg holds:
- the field width constants (same values as the PULSE_REG_* defines);
- pulse_params_t, a packed struct of the six fields;
- the dispatch_state_e enum {IDLE, ISSUE, PLAY, GAP}.

Sub-module rr_arbiter (NUM_CH; inputs req and ptr; outputs grant_oh, grant_idx, any) is a pure-combinational priority rotate, reusable elsewhere. The FSM, slots, countdown and flags live in the top.

Test Plan:
- Single pulse, in time: ch0 tstart=100, tlen=5, loaded at time 90, m_ready=1 → m_valid high for 1 cycle at time 101; busy for 5+2 cycles after the handshake; late_flag=0.
- Round-robin fairness: all 4 channels loaded with tstart=50, tlen=3 → grants in m_ch order 0,1,2,3; a second round starting at ch1 yields order 1,2,3,0.
- Late and backpressure: ch2 tstart=20 loaded at time 40 → late_flag[2]=1; hold m_ready=0 for 6 cycles → m_* stable throughout; late_clr[2] → flag returns to 0.
- Wrap: time_now=0xFFFF_FFF0, ch1 tstart=0x0000_0004 → no grant until time_now=4; grant at time 5.
- Boundaries: tlen=0 with GUARD=0 gives back-to-back grants on every second cycle; a reload into a slot freed at edge k is accepted at edge k+1 at the earliest; asserting rst_n=0 during PLAY → all outputs return to reset values next cycle.

Source files
------------

// File: rtl/pulse_pkg.sv
// Shared pulse descriptor types for the pulse dispatch path.
// Field widths match the PULSE_REG_* register layout.
package pulse_pkg;

    localparam int FREQ_W   = 32;
    localparam int PHASE_W  = 16;
    localparam int AMP_W    = 16;
    localparam int TSTART_W = 32;
    localparam int TLEN_W   = 16;
    localparam int ENV_W    = 10;

    typedef struct packed {
        logic [FREQ_W-1:0]   freq;
        logic [PHASE_W-1:0]  phase;
        logic [AMP_W-1:0]    amp;
        logic [TSTART_W-1:0] tstart;
        logic [TLEN_W-1:0]   tlen;
        logic [ENV_W-1:0]    env;
    } pulse_params_t;

    typedef enum logic [1:0] {IDLE, ISSUE, PLAY, GAP} dispatch_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr,
// wrapping around to channel 0.
module rr_arbiter #(
    parameter  int NUM_CH = 4,
    localparam int IDX_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [NUM_CH-1:0] grant_oh,
    output logic [IDX_W-1:0]  grant_idx,
    output logic              any
);

    localparam int SUM_W = IDX_W + 1;

    logic [SUM_W-1:0] sum;
    logic [IDX_W-1:0] idx;
    logic             found;

    // Scan from ptr upward; sum wraps by subtracting NUM_CH so non-power-of-2 counts work.
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        found     = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            sum = {1'b0, ptr} + SUM_W'(k);
            if (sum >= SUM_W'(NUM_CH)) begin
                sum = sum - SUM_W'(NUM_CH);
            end
            idx = sum[IDX_W-1:0];
            if (!found && req[idx]) begin
                found         = 1'b1;
                grant_oh[idx] = 1'b1;
                grant_idx     = idx;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/pulse_dispatch_arbiter.sv
// Shares one pulse_engine between NUM_CH pulse sources: one-deep slot per channel,
// time-gated round-robin issue, then a t_len + GUARD_CYCLES dead time.
module pulse_dispatch_arbiter
    import pulse_pkg::*;
#(
    parameter  int NUM_CH       = 4,
    parameter  int GUARD_CYCLES = 2,
    localparam int CH_W         = $clog2(NUM_CH)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [TSTART_W-1:0]              time_now,
    input  logic [NUM_CH-1:0]                s_valid,
    output logic [NUM_CH-1:0]                s_ready,
    input  logic [NUM_CH-1:0][FREQ_W-1:0]    s_freq,
    input  logic [NUM_CH-1:0][PHASE_W-1:0]   s_phase,
    input  logic [NUM_CH-1:0][AMP_W-1:0]     s_amp,
    input  logic [NUM_CH-1:0][TSTART_W-1:0]  s_tstart,
    input  logic [NUM_CH-1:0][TLEN_W-1:0]    s_tlen,
    input  logic [NUM_CH-1:0][ENV_W-1:0]     s_env,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [FREQ_W-1:0]                m_freq,
    output logic [PHASE_W-1:0]               m_phase,
    output logic [AMP_W-1:0]                 m_amp,
    output logic [TSTART_W-1:0]              m_tstart,
    output logic [TLEN_W-1:0]                m_tlen,
    output logic [ENV_W-1:0]                 m_env,
    output logic [CH_W-1:0]                  m_ch,
    output logic                             busy,
    output logic [NUM_CH-1:0]                late_flag,
    input  logic [NUM_CH-1:0]                late_clr
);

    dispatch_state_e   state, next_state;
    pulse_params_t     slot [NUM_CH];
    pulse_params_t     m_pulse;
    logic [NUM_CH-1:0] full, elig, grant_oh, late_set;
    logic [CH_W-1:0]   rr_ptr, grant_idx, m_ch_q;
    logic [TLEN_W-1:0] countdown;
    logic              grant_any, grant, hs;

    // Signed modulo difference keeps eligibility correct across counter wrap.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_elig
        logic [TSTART_W-1:0] diff;
        assign diff    = time_now - slot[g].tstart;
        assign elig[g] = full[g] & ~diff[TSTART_W-1];
    end

    rr_arbiter #(.NUM_CH(NUM_CH)) u_rr (
        .req       (elig),
        .ptr       (rr_ptr),
        .grant_oh  (grant_oh),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

    assign grant = (state == IDLE) && grant_any;
    assign hs    = (state == ISSUE) && m_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (grant_any) next_state = ISSUE;
            ISSUE: if (m_ready) begin
                       if (m_pulse.tlen != '0)  next_state = PLAY;
                       else if (GUARD_CYCLES > 0) next_state = GAP;
                       else                       next_state = IDLE;
                   end
            PLAY:  if (countdown == TLEN_W'(1)) next_state = (GUARD_CYCLES > 0) ? GAP : IDLE;
            GAP:   if (countdown == TLEN_W'(1)) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        m_valid = (state == ISSUE);
        busy    = (state != IDLE);
    end

    // Slot occupancy; a slot freed by the handshake only shows ready next cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (hs && m_ch_q == CH_W'(i))       full[i] <= 1'b0;
                else if (s_valid[i] && !full[i])    full[i] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (s_valid[i] && !full[i]) begin
                slot[i] <= {s_freq[i], s_phase[i], s_amp[i], s_tstart[i], s_tlen[i], s_env[i]};
            end
        end
    end

    assign s_ready = ~full;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_pulse <= '0;
            m_ch_q  <= '0;
            rr_ptr  <= '0;
        end else begin
            if (grant) begin
                m_pulse <= slot[grant_idx];
                m_ch_q  <= grant_idx;
            end
            if (hs) rr_ptr <= (m_ch_q == CH_W'(NUM_CH - 1)) ? '0 : m_ch_q + CH_W'(1);
        end
    end

    // One counter serves both the play dwell and the guard gap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            countdown <= '0;
        end else if (hs) begin
            countdown <= (m_pulse.tlen != '0) ? m_pulse.tlen : TLEN_W'(GUARD_CYCLES);
        end else if (state == PLAY && countdown == TLEN_W'(1)) begin
            countdown <= TLEN_W'(GUARD_CYCLES);
        end else if (state == PLAY || state == GAP) begin
            countdown <= countdown - TLEN_W'(1);
        end
    end

    always_comb begin
        late_set = '0;
        if (grant && time_now != slot[grant_idx].tstart) late_set = grant_oh;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) late_flag <= '0;
        else        late_flag <= (late_flag & ~late_clr) | late_set;
    end

    assign m_freq   = m_pulse.freq;
    assign m_phase  = m_pulse.phase;
    assign m_amp    = m_pulse.amp;
    assign m_tstart = m_pulse.tstart;
    assign m_tlen   = m_pulse.tlen;
    assign m_env    = m_pulse.env;
    assign m_ch     = m_ch_q;

endmodule

// File: tb/tb_pulse_dispatch_arbiter.sv
// Directed self-checking bench for pulse_dispatch_arbiter; a second instance
// with GUARD_CYCLES=0 covers the zero-length back-to-back case.
module tb_pulse_dispatch_arbiter;
    import pulse_pkg::*;

    localparam int NUM_CH = 4;

    logic                             clk;
    logic                             rst_n;
    logic [TSTART_W-1:0]              time_now;
    logic [NUM_CH-1:0]                s_valid;
    logic [NUM_CH-1:0][FREQ_W-1:0]    s_freq;
    logic [NUM_CH-1:0][PHASE_W-1:0]   s_phase;
    logic [NUM_CH-1:0][AMP_W-1:0]     s_amp;
    logic [NUM_CH-1:0][TSTART_W-1:0]  s_tstart;
    logic [NUM_CH-1:0][TLEN_W-1:0]    s_tlen;
    logic [NUM_CH-1:0][ENV_W-1:0]     s_env;
    logic                             m_ready;
    logic [NUM_CH-1:0]                late_clr;

    logic [NUM_CH-1:0]   s_ready, late_flag;
    logic                m_valid, busy;
    logic [FREQ_W-1:0]   m_freq;
    logic [PHASE_W-1:0]  m_phase;
    logic [AMP_W-1:0]    m_amp;
    logic [TSTART_W-1:0] m_tstart;
    logic [TLEN_W-1:0]   m_tlen;
    logic [ENV_W-1:0]    m_env;
    logic [1:0]          m_ch;

    logic [NUM_CH-1:0]   g0_s_ready, g0_late_flag;
    logic                g0_m_valid, g0_busy;
    logic [FREQ_W-1:0]   g0_m_freq;
    logic [PHASE_W-1:0]  g0_m_phase;
    logic [AMP_W-1:0]    g0_m_amp;
    logic [TSTART_W-1:0] g0_m_tstart;
    logic [TLEN_W-1:0]   g0_m_tlen;
    logic [ENV_W-1:0]    g0_m_env;
    logic [1:0]          g0_m_ch;

    int checks   = 0;
    int failures = 0;

    pulse_dispatch_arbiter #(.NUM_CH(NUM_CH), .GUARD_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .time_now(time_now),
        .s_valid(s_valid), .s_ready(s_ready),
        .s_freq(s_freq), .s_phase(s_phase), .s_amp(s_amp),
        .s_tstart(s_tstart), .s_tlen(s_tlen), .s_env(s_env),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_freq(m_freq), .m_phase(m_phase), .m_amp(m_amp),
        .m_tstart(m_tstart), .m_tlen(m_tlen), .m_env(m_env),
        .m_ch(m_ch), .busy(busy), .late_flag(late_flag), .late_clr(late_clr)
    );

    pulse_dispatch_arbiter #(.NUM_CH(NUM_CH), .GUARD_CYCLES(0)) dut_g0 (
        .clk(clk), .rst_n(rst_n), .time_now(time_now),
        .s_valid(s_valid), .s_ready(g0_s_ready),
        .s_freq(s_freq), .s_phase(s_phase), .s_amp(s_amp),
        .s_tstart(s_tstart), .s_tlen(s_tlen), .s_env(s_env),
        .m_valid(g0_m_valid), .m_ready(m_ready),
        .m_freq(g0_m_freq), .m_phase(g0_m_phase), .m_amp(g0_m_amp),
        .m_tstart(g0_m_tstart), .m_tlen(g0_m_tlen), .m_env(g0_m_env),
        .m_ch(g0_m_ch), .busy(g0_busy), .late_flag(g0_late_flag), .late_clr(late_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] expFreq(input int ch, input logic [31:0] ts);
        return 32'hA500_0000 | (32'(ch) << 16) | {16'h0, ts[15:0]};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock: inputs and samples both live 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        time_now = time_now + 32'd1;
    endtask

    task automatic applyStimulus(input int ch, input logic [31:0] tstart, input logic [15:0] tlen);
        logic [1:0] c;
        c = 2'(ch);
        s_freq[c]   = expFreq(ch, tstart);
        s_phase[c]  = 16'h1100 + 16'(ch);
        s_amp[c]    = 16'h2200 + 16'(ch);
        s_tstart[c] = tstart;
        s_tlen[c]   = tlen;
        s_env[c]    = 10'h100 + 10'(ch);
        s_valid[c]  = 1'b1;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        s_valid = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic waitValid(input int budget, output bit ok);
        int n;
        n = 0;
        while (!m_valid && n < budget) begin
            tick();
            n++;
        end
        ok = m_valid;
    endtask

    initial begin
        bit ok, early;
        int cnt, n;
        int got_ch[$];
        int got_t[$];

        time_now = '0; s_valid = '0; m_ready = 1'b1; late_clr = '0;
        s_freq = '0; s_phase = '0; s_amp = '0; s_tstart = '0; s_tlen = '0; s_env = '0;
        rst_n = 1'b0;

        $display("[TB] reset values");
        doReset();
        checkOutput("rst_s_ready", 64'(s_ready), 64'hF);
        checkOutput("rst_m_valid", 64'(m_valid), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_late", 64'(late_flag), 64'd0);
        checkOutput("rst_fields", 64'({m_freq, m_tstart}), 64'd0);

        $display("[TB] single in-time pulse");
        time_now = 32'd90;
        applyStimulus(0, 32'd100, 16'd5);
        tick();
        s_valid = '0;
        checkOutput("t1_s_ready_full", 64'(s_ready), 64'hE);
        early = 1'b0;
        n = 0;
        while (time_now != 32'd101 && n < 50) begin
            if (m_valid) early = 1'b1;
            tick();
            n++;
        end
        checkOutput("t1_no_early", 64'(early), 64'd0);
        checkOutput("t1_valid", 64'(m_valid), 64'd1);
        checkOutput("t1_ch", 64'(m_ch), 64'd0);
        checkOutput("t1_freq", 64'(m_freq), 64'(expFreq(0, 32'd100)));
        checkOutput("t1_tstart_tlen", 64'({m_tstart, m_tlen}), {32'd100, 16'd5});
        checkOutput("t1_phase_amp_env", 64'({m_phase, m_amp, m_env}), 64'({16'h1100, 16'h2200, 10'h100}));
        tick();
        checkOutput("t1_valid_one_cycle", 64'(m_valid), 64'd0);
        checkOutput("t1_slot_freed", 64'(s_ready), 64'hF);
        cnt = 0;
        while (busy && cnt < 30) begin
            cnt++;
            tick();
        end
        checkOutput("t1_busy_len", 64'(cnt), 64'd7);
        checkOutput("t1_late", 64'(late_flag), 64'd0);

        $display("[TB] round-robin fairness");
        doReset();
        time_now = 32'd45;
        for (int c = 0; c < 4; c++) applyStimulus(c, 32'd50, 16'd3);
        tick();
        s_valid = '0;
        n = 0;
        while (got_ch.size() < 4 && n < 200) begin
            if (m_valid) begin
                got_ch.push_back(int'(m_ch));
                got_t.push_back(int'(time_now));
            end
            tick();
            n++;
        end
        checkOutput("rr1_count", 64'(got_ch.size()), 64'd4);
        for (int i = 0; i < got_ch.size(); i++) checkOutput("rr1_order", 64'(got_ch[i]), 64'(i));
        if (got_t.size() >= 2) begin
            checkOutput("rr1_first_time", 64'(got_t[0]), 64'd51);
            checkOutput("rr1_spacing", 64'(got_t[1] - got_t[0]), 64'd7);
        end
        checkOutput("rr1_late", 64'(late_flag), 64'hE);
        n = 0;
        while (busy && n < 50) begin tick(); n++; end
        applyStimulus(0, time_now, 16'd3);
        tick();
        s_valid = '0;
        waitValid(20, ok);
        checkOutput("rr2_lead_ok", 64'(ok), 64'd1);
        checkOutput("rr2_lead_ch", 64'(m_ch), 64'd0);
        tick();
        for (int c = 0; c < 4; c++) applyStimulus(c, time_now, 16'd3);
        tick();
        s_valid = '0;
        got_ch.delete();
        n = 0;
        while (got_ch.size() < 4 && n < 200) begin
            if (m_valid) got_ch.push_back(int'(m_ch));
            tick();
            n++;
        end
        checkOutput("rr2_count", 64'(got_ch.size()), 64'd4);
        for (int i = 0; i < got_ch.size(); i++) checkOutput("rr2_order", 64'(got_ch[i]), 64'((i + 1) % 4));

        $display("[TB] late grant with backpressure");
        doReset();
        time_now = 32'd40;
        m_ready = 1'b0;
        applyStimulus(2, 32'd20, 16'd2);
        tick();
        s_valid = '0;
        tick();
        checkOutput("t3_valid", 64'(m_valid), 64'd1);
        checkOutput("t3_late_set", 64'(late_flag), 64'h4);
        for (int k = 0; k < 6; k++) begin
            checkOutput("t3_hold_ctl", 64'({m_valid, m_ch, m_tlen}), 64'({1'b1, 2'd2, 16'd2}));
            checkOutput("t3_hold_data", 64'({m_freq, m_tstart}), {expFreq(2, 32'd20), 32'd20});
            tick();
        end
        m_ready = 1'b1;
        tick();
        checkOutput("t3_released", 64'(m_valid), 64'd0);
        checkOutput("t3_slot_freed", 64'(s_ready), 64'hF);
        checkOutput("t3_late_sticky", 64'(late_flag), 64'h4);
        late_clr = 4'b0100;
        tick();
        late_clr = '0;
        checkOutput("t3_late_clr", 64'(late_flag), 64'd0);

        $display("[TB] counter wrap");
        doReset();
        time_now = 32'hFFFF_FFF0;
        applyStimulus(1, 32'd4, 16'd1);
        tick();
        s_valid = '0;
        early = 1'b0;
        n = 0;
        while (time_now != 32'd5 && n < 100) begin
            if (m_valid) early = 1'b1;
            tick();
            n++;
        end
        checkOutput("t4_no_early", 64'(early), 64'd0);
        checkOutput("t4_grant_at_5", 64'({m_valid, m_ch}), 64'({1'b1, 2'd1}));
        checkOutput("t4_late", 64'(late_flag), 64'd0);

        $display("[TB] reload into freed slot");
        checkOutput("t5_not_ready_issue", 64'(s_ready[1]), 64'd0);
        applyStimulus(1, 32'h0001_0000, 16'd1);
        tick();
        checkOutput("t5_ready_after_free", 64'(s_ready[1]), 64'd1);
        tick();
        s_valid = '0;
        checkOutput("t5_reloaded", 64'(s_ready[1]), 64'd0);

        $display("[TB] reset during PLAY");
        applyStimulus(0, time_now, 16'd10);
        tick();
        s_valid = '0;
        waitValid(20, ok);
        checkOutput("t6_grant_ok", 64'(ok), 64'd1);
        tick();
        tick();
        tick();
        checkOutput("t6_busy_play", 64'(busy), 64'd1);
        checkOutput("t6_pre_state", 64'({s_ready, late_flag}), 64'({4'b1101, 4'b0001}));
        rst_n = 1'b0;
        tick();
        checkOutput("t6_rst_ctl", 64'({m_valid, busy, s_ready, late_flag, m_ch}), 64'({1'b0, 1'b0, 4'hF, 4'h0, 2'd0}));
        checkOutput("t6_rst_fields", 64'({m_freq, m_tlen}), 64'd0);
        rst_n = 1'b1;
        tick();

        $display("[TB] zero length, zero guard");
        m_ready = 1'b1;
        for (int c = 0; c < 4; c++) applyStimulus(c, time_now, 16'd0);
        tick();
        s_valid = '0;
        for (int k = 0; k < 8; k++) begin
            tick();
            checkOutput("t7_valid_pattern", 64'(g0_m_valid), 64'((k % 2) == 0));
            if ((k % 2) == 0) checkOutput("t7_ch", 64'(g0_m_ch), 64'(k / 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
